// File: rtl/reaction_timer_if.sv
// reaction_timer_if
//   Command/status bundle between the reaction-game controller and the
//   reaction_timer back-end.
//
//   Controller -> timer : start_delay, cancel, start_timer, stop_timer
//   Timer -> controller : delay_done (1-cycle pulse), elapsed_time[13:0] (ms),
//                         running, overflow
//
//   modport master : the game controller side
//   modport slave  : the reaction_timer side
interface reaction_timer_if;
    logic        start_delay;
    logic        cancel;
    logic        start_timer;
    logic        stop_timer;
    logic        delay_done;
    logic [13:0] elapsed_time;
    logic        running;
    logic        overflow;

    modport master (
        output start_delay, cancel, start_timer, stop_timer,
        input  delay_done, elapsed_time, running, overflow
    );

    modport slave (
        input  start_delay, cancel, start_timer, stop_timer,
        output delay_done, elapsed_time, running, overflow
    );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer
//   Timing back-end for the reaction-time game. Two independent engines:
//     - a random foreperiod generator that emits a one-cycle delay_done pulse
//       MIN_DELAY_MS .. MIN_DELAY_MS+RANGE_MASK ms after start_delay
//       (abortable with cancel, which outranks start_delay);
//     - a millisecond reaction counter cleared/started by start_timer, frozen
//       by stop_timer, saturating at 9999 with an overflow flag.
//   A free-running 16-bit Galois LFSR supplies the random part of the delay.
//
//   Ports:
//     clk   : system clock, all state changes on the rising edge
//     reset : asynchronous, active-high reset
//     bus   : reaction_timer_if.slave (commands in, delay_done /
//             elapsed_time / running / overflow out, all registered)
//
//   Parameters:
//     TICK_DIV     : clock cycles per ms tick (>= 2)
//     MIN_DELAY_MS : minimum foreperiod in ms
//     RANGE_MASK   : mask on LFSR bits [10:0] forming the random part
//     LFSR_SEED    : non-zero LFSR reset value
module reaction_timer #(
    parameter int          TICK_DIV     = 10000,
    parameter logic [11:0] MIN_DELAY_MS = 12'd1000,
    parameter logic [10:0] RANGE_MASK   = 11'h7FF,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic             clk,
    input logic             reset,
    reaction_timer_if.slave bus
);

    localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]    MAX_MS    = 14'd9999;

    localparam logic [0:0] D_IDLE  = 1'b0;
    localparam logic [0:0] D_COUNT = 1'b1;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_RUN  = 2'd1;
    localparam logic [1:0] T_HOLD = 2'd2;

    logic [15:0]   lfsr_q, lfsr_d;

    logic [0:0]    dState_q, dState_d;
    logic [11:0]   remaining_q, remaining_d;
    logic [PW-1:0] dPresc_q, dPresc_d;
    logic          delayDone_q, delayDone_d;

    logic [1:0]    tState_q, tState_d;
    logic [13:0]   elapsed_q, elapsed_d;
    logic [PW-1:0] tPresc_q, tPresc_d;
    logic          overflow_q, overflow_d;

    logic          dTick;
    logic          tTick;

    // A tick fires on the edge where the prescaler wraps, i.e. TICK_DIV
    // edges after the edge that cleared it.
    assign dTick = (dPresc_q == TICK_LAST);
    assign tTick = (tPresc_q == TICK_LAST);

    // Galois LFSR, x^16+x^14+x^13+x^11, free-running every clock.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    // Foreperiod engine. cancel outranks start_delay; a start_delay while
    // already counting simply recaptures a fresh random value.
    always_comb begin
        dState_d    = dState_q;
        remaining_d = remaining_q;
        dPresc_d    = dPresc_q;
        delayDone_d = 1'b0;
        if (bus.cancel) begin
            dState_d = D_IDLE;
            dPresc_d = '0;
        end else if (bus.start_delay) begin
            remaining_d = MIN_DELAY_MS + {1'b0, lfsr_q[10:0] & RANGE_MASK};
            dPresc_d    = '0;
            dState_d    = D_COUNT;
        end else if (dState_q == D_COUNT) begin
            if (dTick) begin
                dPresc_d    = '0;
                remaining_d = remaining_q - 12'd1;
                // <= 1 so a zero-length delay still ends instead of wrapping.
                if (remaining_q <= 12'd1) begin
                    remaining_d = '0;
                    delayDone_d = 1'b1;
                    dState_d    = D_IDLE;
                end
            end else begin
                dPresc_d = dPresc_q + PW'(1);
            end
        end
    end

    // Reaction counter. start_timer outranks stop_timer; a stop on a tick
    // edge discards that tick so the frozen value is the pre-edge value.
    always_comb begin
        tState_d   = tState_q;
        elapsed_d  = elapsed_q;
        tPresc_d   = tPresc_q;
        overflow_d = overflow_q;
        if (bus.start_timer) begin
            tState_d   = T_RUN;
            elapsed_d  = '0;
            tPresc_d   = '0;
            overflow_d = 1'b0;
        end else if (tState_q == T_RUN) begin
            if (bus.stop_timer) begin
                tState_d = T_HOLD;
            end else if (tTick) begin
                tPresc_d = '0;
                if (elapsed_q < MAX_MS) begin
                    elapsed_d = elapsed_q + 14'd1;
                    if (elapsed_q == MAX_MS - 14'd1) begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                tPresc_d = tPresc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q      <= LFSR_SEED;
            dState_q    <= D_IDLE;
            remaining_q <= '0;
            dPresc_q    <= '0;
            delayDone_q <= 1'b0;
            tState_q    <= T_IDLE;
            elapsed_q   <= '0;
            tPresc_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            dState_q    <= dState_d;
            remaining_q <= remaining_d;
            dPresc_q    <= dPresc_d;
            delayDone_q <= delayDone_d;
            tState_q    <= tState_d;
            elapsed_q   <= elapsed_d;
            tPresc_q    <= tPresc_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.delay_done   = delayDone_q;
    assign bus.elapsed_time = elapsed_q;
    assign bus.running      = (tState_q == T_RUN);
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer
//   Directed bench for reaction_timer with TICK_DIV=4, MIN_DELAY_MS=10,
//   RANGE_MASK=7. Inputs change on the falling edge, outputs are sampled on
//   the falling edge. "Edge 0" is the rising edge that samples a command.
//   From LFSR seed 16'hACE1 the state after 6 shifts is 16'hB313, whose low
//   three bits are 3, giving a 13 ms foreperiod (pulse after edge 52).
module tb_reaction_timer;

    localparam int          TICK_DIV     = 4;
    localparam logic [11:0] MIN_DELAY_MS = 12'd10;
    localparam logic [10:0] RANGE_MASK   = 11'h007;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [15:0] lfsrModel;

    reaction_timer_if bus ();

    reaction_timer #(
        .TICK_DIV    (TICK_DIV),
        .MIN_DELAY_MS(MIN_DELAY_MS),
        .RANGE_MASK  (RANGE_MASK),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR, used to predict the delay captured by start_delay.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsrModel <= 16'hACE1;
        else       lfsrModel <= lfsrModel[0] ? ((lfsrModel >> 1) ^ 16'hB400) : (lfsrModel >> 1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drives start_delay through one rising edge and returns the predicted delay.
    task automatic fireStartDelay(output int d);
        d = int'(MIN_DELAY_MS) + int'(lfsrModel[2:0]);
        bus.start_delay = 1'b1;
        step(1);
        bus.start_delay = 1'b0;
    endtask

    // Counts delay_done pulses over the next 'edges' edges after edge 0.
    task automatic observeDelay(input int edges, output int firstEdge, output int highCount);
        firstEdge = -1;
        highCount = 0;
        for (int k = 1; k <= edges; k++) begin
            step(1);
            if (bus.delay_done === 1'b1) begin
                highCount++;
                if (firstEdge < 0) firstEdge = k;
            end
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.start_delay = 1'b0;
        bus.cancel      = 1'b0;
        bus.start_timer = 1'b0;
        bus.stop_timer  = 1'b0;
        reset = 1'b1;
        step(2);
        testsRun++;
        if (bus.elapsed_time !== 14'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_elapsed: got %0d expected 0", bus.elapsed_time);
        end
        testsRun++;
        if (bus.delay_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_delay_done: got %b expected 0", bus.delay_done);
        end
        testsRun++;
        if (bus.running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_running: got %b expected 0", bus.running);
        end
        testsRun++;
        if (bus.overflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow);
        end
        releaseReset();
    endtask

    // Seeded foreperiod: start_delay sampled with lfsr[2:0]=3 -> pulse after edge 52.
    task automatic test_seed_delay(input string tag);
        int d, firstEdge, highCount;
        step(6);
        fireStartDelay(d);
        observeDelay(70, firstEdge, highCount);
        testsRun++;
        if (firstEdge !== 52) begin
            testsFailed++;
            $display("[TB] FAIL %s_pulse_edge: got %0d expected 52", tag, firstEdge);
        end
        testsRun++;
        if (highCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL %s_pulse_count: got %0d expected 1", tag, highCount);
        end
    endtask

    task automatic test_cancel();
        int d, firstEdge, highCount;
        fireStartDelay(d);
        step(19);
        bus.cancel = 1'b1;
        step(1);
        bus.cancel = 1'b0;
        observeDelay(180, firstEdge, highCount);
        testsRun++;
        if (highCount !== 0) begin
            testsFailed++;
            $display("[TB] FAIL cancel_no_pulse: got %0d pulses expected 0", highCount);
        end
        fireStartDelay(d);
        observeDelay(d * TICK_DIV + 10, firstEdge, highCount);
        testsRun++;
        if (firstEdge !== d * TICK_DIV || highCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL cancel_restart: got edge %0d count %0d expected edge %0d count 1",
                     firstEdge, highCount, d * TICK_DIV);
        end
        bus.cancel      = 1'b1;
        bus.start_delay = 1'b1;
        step(1);
        bus.cancel      = 1'b0;
        bus.start_delay = 1'b0;
        observeDelay(100, firstEdge, highCount);
        testsRun++;
        if (highCount !== 0) begin
            testsFailed++;
            $display("[TB] FAIL cancel_priority: got %0d pulses expected 0", highCount);
        end
    endtask

    task automatic test_back_to_back();
        int da, db, firstEdge, highCount;
        fireStartDelay(da);
        step(19);
        fireStartDelay(db);
        observeDelay(db * TICK_DIV + 10, firstEdge, highCount);
        testsRun++;
        if (firstEdge !== db * TICK_DIV || highCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back: got edge %0d count %0d expected edge %0d count 1",
                     firstEdge, highCount, db * TICK_DIV);
        end
    endtask

    task automatic test_timer_stop();
        bus.start_timer = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        testsRun++;
        if (bus.running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stop_running_rise: got %b expected 1", bus.running);
        end
        step(7);
        testsRun++;
        if (bus.elapsed_time !== 14'd1) begin
            testsFailed++;
            $display("[TB] FAIL stop_edge7: got %0d expected 1", bus.elapsed_time);
        end
        step(1);
        testsRun++;
        if (bus.elapsed_time !== 14'd2) begin
            testsFailed++;
            $display("[TB] FAIL stop_edge8: got %0d expected 2", bus.elapsed_time);
        end
        step(21);
        bus.stop_timer = 1'b1;
        step(1);
        bus.stop_timer = 1'b0;
        testsRun++;
        if (bus.elapsed_time !== 14'd7 || bus.running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stop_edge30: got %0d running %b expected 7 running 0",
                     bus.elapsed_time, bus.running);
        end
        step(100);
        testsRun++;
        if (bus.elapsed_time !== 14'd7) begin
            testsFailed++;
            $display("[TB] FAIL stop_hold: got %0d expected 7", bus.elapsed_time);
        end
    endtask

    task automatic test_stop_on_tick();
        bus.start_timer = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(31);
        testsRun++;
        if (bus.elapsed_time !== 14'd7) begin
            testsFailed++;
            $display("[TB] FAIL tickstop_edge31: got %0d expected 7", bus.elapsed_time);
        end
        bus.stop_timer = 1'b1;
        step(1);
        bus.stop_timer = 1'b0;
        step(8);
        testsRun++;
        if (bus.elapsed_time !== 14'd7 || bus.running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tickstop_frozen: got %0d running %b expected 7 running 0",
                     bus.elapsed_time, bus.running);
        end
    endtask

    task automatic test_saturation();
        bus.start_timer = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(39995);
        testsRun++;
        if (bus.elapsed_time !== 14'd9998 || bus.overflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_edge39995: got %0d ovf %b expected 9998 ovf 0",
                     bus.elapsed_time, bus.overflow);
        end
        step(1);
        testsRun++;
        if (bus.elapsed_time !== 14'd9999) begin
            testsFailed++;
            $display("[TB] FAIL sat_edge39996: got %0d expected 9999", bus.elapsed_time);
        end
        step(8);
        testsRun++;
        if (bus.elapsed_time !== 14'd9999 || bus.overflow !== 1'b1 || bus.running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_hold: got %0d ovf %b running %b expected 9999 ovf 1 running 1",
                     bus.elapsed_time, bus.overflow, bus.running);
        end
        bus.start_timer = 1'b1;
        bus.stop_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        bus.stop_timer  = 1'b0;
        testsRun++;
        if (bus.elapsed_time !== 14'd0 || bus.overflow !== 1'b0 || bus.running !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_restart: got %0d ovf %b running %b expected 0 ovf 0 running 1",
                     bus.elapsed_time, bus.overflow, bus.running);
        end
    endtask

    task automatic test_reset_midcount();
        int d;
        fireStartDelay(d);
        step(25);
        testsRun++;
        if (bus.elapsed_time === 14'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_precount: got %0d expected nonzero", bus.elapsed_time);
        end
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if (bus.elapsed_time !== 14'd0 || bus.running !== 1'b0 ||
            bus.delay_done !== 1'b0 || bus.overflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got elapsed %0d running %b done %b ovf %b expected all 0",
                     bus.elapsed_time, bus.running, bus.delay_done, bus.overflow);
        end
        step(2);
        releaseReset();
        test_seed_delay("midreset");
        testsRun++;
        if (bus.elapsed_time !== 14'd0 || bus.running !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_timer_idle: got %0d running %b expected 0 running 0",
                     bus.elapsed_time, bus.running);
        end
    endtask

    initial begin
        test_reset();
        test_seed_delay("seed");
        test_cancel();
        test_back_to_back();
        test_timer_stop();
        test_stop_on_tick();
        test_saturation();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
